yu_yg: RTL and testbench



---
 rtl/yu_yg_pkg.sv | 13 +
 rtl/yu_yg_dec2to4_n.sv | 23 ++
 rtl/yu_yg.sv | 60 ++++++
 tb/tb_yu_yg.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/yu_yg_pkg.sv
// Shared constants for the yu_yg decode-and-qualify cell and its 2-to-4 decoder.
package yu_yg_pkg;

  localparam int DEC_SEL_W = 2;
  localparam int DEC_OUT_W = 4;

  // Decoder minterms whose active-low outputs combine into A^B
  localparam int MT_XOR_LO = 1;
  localparam int MT_XOR_HI = 2;

  localparam logic [DEC_OUT_W-1:0] DEC_IDLE = 4'b1111;

endpackage

// File: rtl/yu_yg_dec2to4_n.sv
// Gate-level 2-to-4 decoder: active-high enable, active-low outputs.
module dec2to4_n
  import yu_yg_pkg::*;
(
  input  logic                 en,
  input  logic                 a,
  input  logic                 b,
  output logic [DEC_OUT_W-1:0] y_n
);

  logic w_a_n;
  logic w_b_n;

  assign w_a_n  = ~a;
  assign w_b_n  = ~b;

  // One 3-input NAND per minterm; a is the select MSB
  assign y_n[0] = ~(en & w_a_n & w_b_n);
  assign y_n[1] = ~(en & w_a_n & b);
  assign y_n[2] = ~(en & a & w_b_n);
  assign y_n[3] = ~(en & a & b);

endmodule

// File: rtl/yu_yg.sv
// Registered F = en & (A^B) & (C | ~D), built around an active-low 2-to-4 decoder.
// Define YU_YG_DEC_OBS_EN to expose the registered decoder word on dec_n.
module yu_yg
  import yu_yg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 A,
  input  logic                 B,
  input  logic                 C,
  input  logic                 D,
`ifdef YU_YG_DEC_OBS_EN
  output logic [DEC_OUT_W-1:0] dec_n,
`endif
  output logic                 F
);

  logic [DEC_OUT_W-1:0] w_y_n;
  logic                 w_x;
  logic                 w_d_n;
  logic                 w_q;
  logic                 w_f_d;
  logic                 r_f;

  dec2to4_n u_dec (
    .en  (en),
    .a   (A),
    .b   (B),
    .y_n (w_y_n)
  );

  // Minterms 1 and 2 low means exactly one select bit is set, so the NAND yields A^B
  assign w_x   = ~(w_y_n[MT_XOR_LO] & w_y_n[MT_XOR_HI]);
  assign w_d_n = ~D;
  assign w_q   = C | w_d_n;
  assign w_f_d = w_x & w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_f <= 1'b0;
    else     r_f <= w_f_d;
  end

  assign F = r_f;

`ifdef YU_YG_DEC_OBS_EN
  logic [DEC_OUT_W-1:0] r_dec_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dec_n <= DEC_IDLE;
    else     r_dec_n <= w_y_n;
  end

  assign dec_n = r_dec_n;
`else
  logic w_unused_dec;
  assign w_unused_dec = w_y_n[0] ^ w_y_n[3];
`endif

endmodule

// File: tb/tb_yu_yg.sv
// Self-checking bench for yu_yg: per-cycle reference model plus literal directed checks.
module tb_yu_yg;

  logic       clk;
  logic       rst;
  logic       en, A, B, C, D;
  logic       F;
`ifdef YU_YG_DEC_OBS_EN
  logic [3:0] dec_n;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 0;

  logic       m_f;
  logic [3:0] m_dec;

  yu_yg dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
`ifdef YU_YG_DEC_OBS_EN
    .dec_n (dec_n),
`endif
    .F     (F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: F is the boolean rule on the previous edge's inputs; the decoder word has a
  // single zero at position {A,B} when enabled
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_f   <= 1'b0;
      m_dec <= 4'b1111;
    end else begin
      m_f   <= en && (A != B) && (C || !D);
      m_dec <= en ? ~(4'b0001 << {A, B}) : 4'b1111;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_F", {3'b000, F}, {3'b000, m_f});
`ifdef YU_YG_DEC_OBS_EN
      chk("model_dec_n", dec_n, m_dec);
`endif
    end
  end

  task automatic drive(input logic e, input logic [3:0] abcd);
    @(negedge clk);
    en = e;
    {A, B, C, D} = abcd;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sweep_exp;

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    {A, B, C, D} = 4'b0000;
    sweep_exp = 16'b0000_1101_1101_0000; // bit i = F for ABCD==i, en=1
    #1;
    chk("reset_F", {3'b000, F}, 4'b0000);
`ifdef YU_YG_DEC_OBS_EN
    chk("reset_dec_n", dec_n, 4'b1111);
`endif
    after_edge();
    chk("reset_hold_F", {3'b000, F}, 4'b0000);
    run_cmp = 1'b1;

    // Release, capture F=1, then assert reset between edges
    drive(1'b1, 4'b0100);
    rst = 1'b0;
    after_edge();
    chk("pre_reset_F", {3'b000, F}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_F", {3'b000, F}, 4'b0000);
`ifdef YU_YG_DEC_OBS_EN
    chk("async_reset_dec_n", dec_n, 4'b1111);
`endif
    @(negedge clk);
    rst = 1'b0;

    // en=1 sweep
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      after_edge();
      chk($sformatf("sweep_en1_%0d", i), {3'b000, F}, {3'b000, sweep_exp[i]});
    end

    // en=0 sweep
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i));
      after_edge();
      chk($sformatf("sweep_en0_%0d", i), {3'b000, F}, 4'b0000);
`ifdef YU_YG_DEC_OBS_EN
      chk($sformatf("sweep_en0_dec_%0d", i), dec_n, 4'b1111);
`endif
    end

`ifdef YU_YG_DEC_OBS_EN
    drive(1'b1, 4'b0000); after_edge(); chk("dec_ab00", dec_n, 4'b1110);
    drive(1'b1, 4'b0100); after_edge(); chk("dec_ab01", dec_n, 4'b1101);
    drive(1'b1, 4'b1000); after_edge(); chk("dec_ab10", dec_n, 4'b1011);
    drive(1'b1, 4'b1100); after_edge(); chk("dec_ab11", dec_n, 4'b0111);
`endif

    // en toggle with ABCD=1000 held
    drive(1'b1, 4'b1000); after_edge(); chk("en_tog_1", {3'b000, F}, 4'b0001);
    drive(1'b0, 4'b1000); after_edge(); chk("en_tog_0", {3'b000, F}, 4'b0000);
    drive(1'b1, 4'b1000); after_edge(); chk("en_tog_1b", {3'b000, F}, 4'b0001);

    // Reset pulse entirely between edges mid-operation
    drive(1'b1, 4'b0111);
    after_edge();
    chk("mid_pre_F", {3'b000, F}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_F", {3'b000, F}, 4'b0000);
    #1;
    rst = 1'b0;
    after_edge();
    chk("mid_release_F", {3'b000, F}, 4'b0001);

    drive(1'b0, 4'b0000);
    after_edge();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
